// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and coordinate type; imported by the
// timing generator and by the background/object drawers downstream.
package vga_timing_pkg;

  typedef logic [10:0] coord_t;

  localparam coord_t H_VISIBLE    = 11'd640;
  localparam coord_t H_FRONT      = 11'd16;
  localparam coord_t H_SYNC       = 11'd96;
  localparam coord_t H_BACK       = 11'd48;
  localparam coord_t H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam coord_t H_MAX        = H_TOTAL - 11'd1;
  localparam coord_t H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC - 11'd1;

  localparam coord_t V_VISIBLE    = 11'd480;
  localparam coord_t V_FRONT      = 11'd10;
  localparam coord_t V_SYNC       = 11'd2;
  localparam coord_t V_BACK       = 11'd33;
  localparam coord_t V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t V_MAX        = V_TOTAL - 11'd1;
  localparam coord_t V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC - 11'd1;

  // Inclusive range test, kept in unsigned 11-bit arithmetic throughout.
  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: the generator drives it (master), drawers consume it (slave).
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t     pixelX;
  coord_t     pixelY;
  logic       hSyncN;
  logic       vSyncN;
  logic       blankN;
  logic       startOfFrame;
  logic [7:0] frameCount;

  modport master (
    output pixelX, pixelY, hSyncN, vSyncN, blankN, startOfFrame, frameCount
  );

  modport slave (
    input pixelX, pixelY, hSyncN, vSyncN, blankN, startOfFrame, frameCount
  );

endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-(MAX+1) counter advancing on en; wrap flags the enabled MAX->0 step.
module wrap_counter #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned MAX   = 799
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap = en && (count_q == MAX_V);

  always_comb begin
    // NOTE: default assignment first so every path assigns count_d (no latch).
    count_d = count_q;
    if (en) count_d = wrap ? '0 : count_q + 1'b1;
  end

  // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 VGA timing generator with registered outputs, one pixelEn tick behind
// the counters. Define VGA_FRAME_COUNT_EN to build the 8-bit frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              pixelEn,
  vga_timing_gen_if.master  vga
);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_wrap;
  logic   v_wrap;
  logic   v_en;

  assign v_en = pixelEn & h_wrap;

  wrap_counter #(.WIDTH(11), .MAX(int'(H_MAX))) u_h_cnt (
    .clk    (clk),
    .resetN (resetN),
    .en     (pixelEn),
    .count  (h_cnt),
    .wrap   (h_wrap)
  );

  wrap_counter #(.WIDTH(11), .MAX(int'(V_MAX))) u_v_cnt (
    .clk    (clk),
    .resetN (resetN),
    .en     (v_en),
    .count  (v_cnt),
    .wrap   (v_wrap)
  );

  coord_t x_q, y_q;
  logic   hs_q, vs_q, blank_q, sof_q, pend_q;
  logic   hs_d, vs_d, blank_d, sof_d;

  always_comb begin
    hs_d    = !in_range(h_cnt, H_SYNC_START, H_SYNC_END);
    vs_d    = !in_range(v_cnt, V_SYNC_START, V_SYNC_END);
    blank_d = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
    // A frame wrap arms the pulse; it fires on the tick that loads (0,0), so
    // the (0,0) loaded straight out of reset never pulses.
    sof_d   = pixelEn && pend_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      sof_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sof_q <= sof_d;
      if (pixelEn) begin
        x_q     <= h_cnt;
        y_q     <= v_cnt;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        blank_q <= blank_d;
        pend_q  <= v_wrap;
      end
    end
  end

  assign vga.pixelX       = x_q;
  assign vga.pixelY       = y_q;
  assign vga.hSyncN       = hs_q;
  assign vga.vSyncN       = vs_q;
  assign vga.blankN       = blank_q;
  assign vga.startOfFrame = sof_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)    frame_q <= 8'd0;
    else if (sof_d) frame_q <= frame_q + 8'd1;
  end

  assign vga.frameCount = frame_q;
`else
  assign vga.frameCount = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; jumps across the frame by forcing the
// vertical enable so frame-edge regions are reached in a few thousand clocks.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

`ifdef VGA_FRAME_COUNT_EN
  localparam int FC_STEP = 1;
`else
  localparam int FC_STEP = 0;
`endif

  logic clk = 1'b0;
  logic resetN;
  logic pixelEn;

  vga_timing_gen_if vga ();

  vga_timing_gen dut (
    .clk     (clk),
    .resetN  (resetN),
    .pixelEn (pixelEn),
    .vga     (vga)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    coord_t     x;
    coord_t     y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       sof;
    logic [7:0] fc;
  } obs_t;

  obs_t o, e;

  function automatic obs_t sample();
    obs_t s;
    s.x = vga.pixelX; s.y = vga.pixelY; s.hs = vga.hSyncN; s.vs = vga.vSyncN;
    s.bl = vga.blankN; s.sof = vga.startOfFrame; s.fc = vga.frameCount;
    return s;
  endfunction

  function automatic obs_t mk(int x, int y, bit hs, bit vs, bit bl, bit sof, int fc);
    obs_t s;
    s.x = coord_t'(x); s.y = coord_t'(y); s.hs = hs; s.vs = vs;
    s.bl = bl; s.sof = sof; s.fc = 8'(fc);
    return s;
  endfunction

  task automatic tick(input logic en);
    pixelEn = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick(1'b0);
    tick(1'b0);
    resetN = 1'b1;
  endtask

  task automatic jump(input int n);
    force dut.v_en = 1'b1;
    repeat (n) tick(1'b1);
    release dut.v_en;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) tick(1'b1);
    o = sample(); e = mk(0, 0, 1, 1, 0, 0, 0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_hold: got %h want %h", o, e); end
    resetN = 1'b1;
  endtask

  task automatic test_first_edge();
    tick(1'b1);
    o = sample(); e = mk(0, 0, 1, 1, 1, 0, 0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL first_edge: got %h want %h", o, e); end
    tick(1'b1);
    o = sample(); e = mk(1, 0, 1, 1, 1, 0, 0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL second_edge: got %h want %h", o, e); end
  endtask

  task automatic test_pixel_en();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      o = sample(); e = mk(1, 0, 1, 1, 1, 0, 0); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL en_low_hold[%0d]: got %h want %h", i, o, e); end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      o = sample(); e = mk(2 + i, 0, 1, 1, 1, 0, 0); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL toggle_adv[%0d]: got %h want %h", i, o, e); end
      tick(1'b0);
      o = sample(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL toggle_hold[%0d]: got %h want %h", i, o, e); end
    end
    repeat (800) begin
      tick(1'b1);
      tick(1'b0);
    end
    o = sample(); e = mk(5, 1, 1, 1, 1, 0, 0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL line_1600_clks: got %h want %h", o, e); end
  endtask

  task automatic test_hsync_blank();
    int hs_low = 0, first_x = -1, bl639 = -1, bl640 = -1;
    for (int i = 0; i < 800; i++) begin
      tick(1'b1);
      if (vga.hSyncN === 1'b0) begin
        if (first_x < 0) first_x = int'(vga.pixelX);
        hs_low++;
      end
      if (vga.pixelX === 11'd639) bl639 = int'(vga.blankN);
      if (vga.pixelX === 11'd640) bl640 = int'(vga.blankN);
    end
    n_tests++;
    if (hs_low !== 96) begin n_fail++; $display("FAIL hsync_width: got %0d want 96", hs_low); end
    n_tests++;
    if (first_x !== 656) begin n_fail++; $display("FAIL hsync_start: got %0d want 656", first_x); end
    n_tests++;
    if (bl639 !== 1) begin n_fail++; $display("FAIL blank_x639: got %0d want 1", bl639); end
    n_tests++;
    if (bl640 !== 0) begin n_fail++; $display("FAIL blank_x640: got %0d want 0", bl640); end
    o = sample(); e = mk(5, 2, 1, 1, 1, 0, 0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL after_line: got %h want %h", o, e); end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    jump(1574);
    o = sample(); e = mk(773, 523, 1, 1, 0, 0, 2 * FC_STEP); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL jump_pos: got %h want %h", o, e); end
    tick(1'b1);
    o = sample(); e = mk(774, 524, 1, 1, 0, 0, 2 * FC_STEP); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL free_run: got %h want %h", o, e); end
    repeat (25) tick(1'b1);
    o = sample(); e = mk(799, 524, 1, 1, 0, 0, 2 * FC_STEP); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL frame_last: got %h want %h", o, e); end
    tick(1'b1);
    o = sample(); e = mk(0, 0, 1, 1, 1, 1, 3 * FC_STEP); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL frame_wrap_sof: got %h want %h", o, e); end
    tick(1'b0);
    o = sample(); e = mk(0, 0, 1, 1, 1, 0, 3 * FC_STEP); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL sof_one_clk: got %h want %h", o, e); end
    tick(1'b1);
    o = sample(); e = mk(1, 0, 1, 1, 1, 0, 3 * FC_STEP); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL after_wrap: got %h want %h", o, e); end
  endtask

  task automatic test_vsync_vblank();
    int vs_low = 0, first_x = -1, first_y = -1;
    int bl_639_479 = -1, bl_640_479 = -1, bl_0_480 = -1;
    do_reset();
    jump(479);
    for (int i = 0; i < 10400; i++) begin
      tick(1'b1);
      if (vga.vSyncN === 1'b0) begin
        if (first_y < 0) begin
          first_x = int'(vga.pixelX);
          first_y = int'(vga.pixelY);
        end
        vs_low++;
      end
      if (vga.pixelY === 11'd479 && vga.pixelX === 11'd639) bl_639_479 = int'(vga.blankN);
      if (vga.pixelY === 11'd479 && vga.pixelX === 11'd640) bl_640_479 = int'(vga.blankN);
      if (vga.pixelY === 11'd480 && vga.pixelX === 11'd0)   bl_0_480   = int'(vga.blankN);
    end
    n_tests++;
    if (vs_low !== 1600) begin n_fail++; $display("FAIL vsync_width: got %0d want 1600", vs_low); end
    n_tests++;
    if (first_x !== 0 || first_y !== 490) begin
      n_fail++; $display("FAIL vsync_start: got (%0d,%0d) want (0,490)", first_x, first_y);
    end
    n_tests++;
    if (bl_639_479 !== 1) begin n_fail++; $display("FAIL blank_639_479: got %0d want 1", bl_639_479); end
    n_tests++;
    if (bl_640_479 !== 0) begin n_fail++; $display("FAIL blank_640_479: got %0d want 0", bl_640_479); end
    n_tests++;
    if (bl_0_480 !== 0) begin n_fail++; $display("FAIL blank_0_480: got %0d want 0", bl_0_480); end
  endtask

  task automatic test_async_reset();
    int sof_seen = 0;
    do_reset();
    jump(10701);
    o = sample(); e = mk(300, 200, 1, 1, 1, 0, 20 * FC_STEP); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL mid_frame_pos: got %h want %h", o, e); end
    #2;
    resetN = 1'b0;
    #1;
    o = sample(); e = mk(0, 0, 1, 1, 0, 0, 0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL async_reset: got %h want %h", o, e); end
    @(negedge clk);
    tick(1'b1);
    resetN = 1'b1;
    tick(1'b1);
    o = sample(); e = mk(0, 0, 1, 1, 1, 0, 0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL restart_edge: got %h want %h", o, e); end
    for (int i = 0; i < 799; i++) begin
      tick(1'b1);
      if (vga.startOfFrame !== 1'b0) sof_seen++;
    end
    n_tests++;
    if (sof_seen !== 0) begin n_fail++; $display("FAIL spurious_sof: got %0d want 0", sof_seen); end
    o = sample(); e = mk(799, 0, 1, 1, 0, 0, 0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL restart_line: got %h want %h", o, e); end
  endtask

  initial begin
    resetN  = 1'b0;
    pixelEn = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_edge();
    test_pixel_en();
    test_hsync_blank();
    test_frame_wrap();
    test_vsync_vblank();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
